vc_test_rand_delay_source: RTL and testbench

Test-harness message source that feeds a val/rdy sink stage, for example the DUT input or a random-delay unordered sink.
- Holds up to p_num_msgs messages, written through a load port before or during a run.
- Presents the messages in index order on a val/rdy interface.
- Inserts a pseudo-random idle gap of 0..max_delay cycles before each message.
- Raises done once all num_msgs messages have been accepted.

---
 rtl/vc_test_rand_delay_source_pkg.sv | 17 +
 rtl/vc_test_lfsr32.sv | 28 ++
 rtl/vc_test_rand_delay_source.sv | 95 +++++++++
 tb/tb_vc_test_rand_delay_source.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_rand_delay_source_pkg.sv
// Shared constants and helpers for the random-delay test harness blocks.
// The LFSR tap mask and seed are reused by the matching random-delay sink.
package vc_test_rand_delay_source_pkg;

    // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] c_lfsr_taps    = 32'h8020_0003;
    localparam logic [31:0] c_default_seed = 32'hB9A7_4F31;

    function automatic int idx_nbits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? c_lfsr_taps : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/vc_test_lfsr32.sv
// 32-bit Galois LFSR that steps only when enabled; seed reloads on reset.
module vc_test_lfsr32
    import vc_test_rand_delay_source_pkg::*;
#(
    parameter logic [31:0] p_seed = c_default_seed
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] out
);

    logic [31:0] state_r;

    // Hold the seed in reset, advance one step per enable otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= p_seed;
        end else if (en) begin
            state_r <= lfsr_step(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign out = state_r;

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// Message source for val/rdy test harnesses: replays stored messages in order
// with a pseudo-random idle gap of 0..max_delay cycles before each one.
module vc_test_rand_delay_source
    import vc_test_rand_delay_source_pkg::*;
#(
    parameter int          p_msg_nbits = 1,
    parameter int          p_num_msgs  = 1024,
    parameter logic [31:0] p_seed      = c_default_seed,
    localparam int         c_idx_nbits = idx_nbits(p_num_msgs)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic [c_idx_nbits:0]   num_msgs,
    input  logic                   load_en,
    input  logic [c_idx_nbits-1:0] load_addr,
    input  logic [p_msg_nbits-1:0] load_msg,
    output logic                   val,
    input  logic                   rdy,
    output logic [p_msg_nbits-1:0] msg,
    output logic                   done
);

    logic [p_msg_nbits-1:0] mem_r [p_num_msgs];
    logic [c_idx_nbits:0]   idx_r;
    logic [c_idx_nbits:0]   idx_next_s;
    logic [31:0]            dcnt_r;
    logic [31:0]            rnd_s;
    logic [31:0]            lfsr_s;
    logic                   done_r;
    logic                   val_s;
    logic                   fire_s;

    // The source only ever presents when the gap has expired and messages remain.
    assign val_s  = reset & (dcnt_r == 32'd0) & (idx_r < num_msgs) & ~done_r;
    assign fire_s = val_s & rdy;
    assign val    = val_s;
    assign done   = done_r;
    assign msg    = mem_r[idx_r[c_idx_nbits-1:0]];

    vc_test_lfsr32 #(
        .p_seed (p_seed)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (fire_s),
        .out   (lfsr_s)
    );

    // Draw the next gap from the pre-advance LFSR value and form the next index.
    always_comb begin
        rnd_s      = 32'd0;
        idx_next_s = idx_r;
        // max_delay of all-ones means modulo 2^32, which is the LFSR value itself
        if (max_delay == 32'd0) begin
            rnd_s = 32'd0;
        end else if (max_delay == 32'hFFFF_FFFF) begin
            rnd_s = lfsr_s;
        end else begin
            rnd_s = lfsr_s % (max_delay + 32'd1);
        end
        if (fire_s) begin
            idx_next_s = idx_r + (c_idx_nbits+1)'(1);
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Index, gap counter and sticky done flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r  <= '0;
            dcnt_r <= 32'd0;
            done_r <= 1'b0;
        end else begin
            idx_r <= idx_next_s;
            if (fire_s) begin
                dcnt_r <= rnd_s;
            end else if (dcnt_r != 32'd0) begin
                dcnt_r <= dcnt_r - 32'd1;
            end else begin
                dcnt_r <= dcnt_r;
            end
            done_r <= done_r | (idx_next_s >= num_msgs);
        end
    end

    // Message storage survives reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset && load_en) begin
            mem_r[load_addr] <= load_msg;
        end
    end

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Directed self-checking bench for vc_test_rand_delay_source.
module tb_vc_test_rand_delay_source;

    localparam int          W    = 8;
    localparam int          N    = 64;
    localparam int          IW   = 6;
    localparam logic [31:0] SEED = 32'hB9A7_4F31;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   max_delay;
    logic [IW:0]   num_msgs;
    logic          load_en;
    logic [IW-1:0] load_addr;
    logic [W-1:0]  load_msg;
    logic          val;
    logic          rdy;
    logic [W-1:0]  msg;
    logic          done;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] ref_mem [N];
    int           gaps_a  [N];

    always #5 clk = ~clk;

    vc_test_rand_delay_source #(
        .p_msg_nbits (W),
        .p_num_msgs  (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .num_msgs  (num_msgs),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_msg  (load_msg),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    // One reset cycle, then release with the given configuration.
    task automatic start_run(input logic [31:0] md, input int n);
        reset = 1'b0;
        #1;
        check("rst_val", {63'd0, val}, 64'd0);
        step();
        check("rst_done", {63'd0, done}, 64'd0);
        max_delay = md;
        num_msgs  = 7'(n);
        reset     = 1'b1;
        #1;
    endtask

    task automatic run_rand(input int pattern);
        logic [31:0] lfsr;
        int k, gap, exp_gap, cyc;
        start_run(32'd7, N);
        lfsr = SEED; k = 0; gap = 0; exp_gap = 0; cyc = 0;
        while (k < N && cyc < 3000) begin
            rdy = (pattern == 0) ? 1'b1 : ((cyc % 3) != 1);
            #1;
            if (val) begin
                if (rdy) begin
                    check("rand_gap", 64'(gap), 64'(exp_gap));
                    check("rand_msg", {56'd0, msg}, {56'd0, ref_mem[k]});
                    if (pattern == 0) gaps_a[k] = gap;
                    else check("rand_same_gap", 64'(gap), 64'(gaps_a[k]));
                    exp_gap = int'(lfsr % 32'd8);
                    lfsr    = model_next(lfsr);
                    gap     = 0;
                    k       = k + 1;
                end
            end else begin
                gap = gap + 1;
            end
            step();
            cyc = cyc + 1;
        end
        check("rand_count", 64'(k), 64'(N));
        check("rand_done", {63'd0, done}, 64'd1);
        check("rand_val_after", {63'd0, val}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rdy = 1'b1; load_en = 1'b0; load_addr = '0; load_msg = '0;
        max_delay = 32'd0; num_msgs = 7'd0;
        step(); step();

        // num_msgs == 0: val never rises, done sets after the first edge; memory is loaded meanwhile.
        reset = 1'b1;
        #1;
        check("num0_done_pre", {63'd0, done}, 64'd0);
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = (i < 4) ? 8'((i + 1) * 17) : 8'(i * 3 + 1);
            load_en    = 1'b1;
            load_addr  = 6'(i);
            load_msg   = ref_mem[i];
            #1;
            check("num0_val", {63'd0, val}, 64'd0);
            if (i == 1) check("num0_done", {63'd0, done}, 64'd1);
            step();
        end
        load_en = 1'b0;

        // Back-to-back, no delay.
        start_run(32'd0, 4);
        for (int k = 0; k < 4; k++) begin
            check("b2b_val", {63'd0, val}, 64'd1);
            check("b2b_msg", {56'd0, msg}, {56'd0, ref_mem[k]});
            check("b2b_done_low", {63'd0, done}, 64'd0);
            step();
        end
        check("b2b_val_end", {63'd0, val}, 64'd0);
        check("b2b_done", {63'd0, done}, 64'd1);

        // Stall for five cycles, then drain.
        start_run(32'd0, 3);
        rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("stall_val", {63'd0, val}, 64'd1);
            check("stall_msg", {56'd0, msg}, {56'd0, ref_mem[0]});
            step();
        end
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_resume_msg", {56'd0, msg}, {56'd0, ref_mem[k]});
            check("stall_resume_val", {63'd0, val}, 64'd1);
            step();
        end
        check("stall_done", {63'd0, done}, 64'd1);

        // Random gaps against the golden LFSR, with and without stalls.
        run_rand(0);
        run_rand(1);
        rdy = 1'b1;

        // Reset mid-run at idx 2; a load attempted during reset must be dropped.
        start_run(32'd0, 4);
        step(); step();
        check("mid_pre_msg", {56'd0, msg}, {56'd0, ref_mem[2]});
        reset     = 1'b0;
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_msg  = 8'hEE;
        #1;
        check("mid_rst_val", {63'd0, val}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        step();
        load_en = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_restart_val", {63'd0, val}, 64'd1);
        check("mid_restart_msg", {56'd0, msg}, {56'd0, ref_mem[0]});

        // Overwrite the entry currently presented while stalled.
        start_run(32'd0, 8);
        for (int k = 0; k < 5; k++) begin
            check("ld_pre_msg", {56'd0, msg}, {56'd0, ref_mem[k]});
            step();
        end
        rdy       = 1'b0;
        load_en   = 1'b1;
        load_addr = 6'd5;
        load_msg  = 8'hAB;
        #1;
        check("ld_val", {63'd0, val}, 64'd1);
        check("ld_old", {56'd0, msg}, {56'd0, ref_mem[5]});
        step();
        load_en    = 1'b0;
        ref_mem[5] = 8'hAB;
        check("ld_new", {56'd0, msg}, 64'h0000_0000_0000_00AB);
        rdy = 1'b1;
        #1;
        check("ld_fire_val", {63'd0, val}, 64'd1);
        step();
        check("ld_after", {56'd0, msg}, {56'd0, ref_mem[6]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
